// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master.
// Word width, clock divider and chip-select count are parameters. CPOL/CPHA
// and the chip select are latched at start and held for the whole transfer.
module spi_master_param #(
  parameter int DATA_W = 16,
  parameter int DIV    = 2,
  parameter int N_CS   = 2,
  parameter int SEL_W  = 1
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [SEL_W-1:0]  cs_sel,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              spi_clk,
  output logic [N_CS-1:0]   cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TCK_W = $clog2(2 * DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV - 1);
  localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(2 * DATA_W - 1);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, TRAIL} state_t;

  state_t             state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [TCK_W-1:0]   tcnt;     // spi_clk toggles already made
  logic               cpha_q;
  logic [DATA_W-1:0]  tx_sh;
  logic [DATA_W-1:0]  rx_sh;

  logic               wrap;
  logic               tog;
  logic               lead_edge;
  logic               trail_edge;
  logic               last_tog;
  logic [N_CS-1:0]    cs_dec;

  // State register
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (start) next_state = LEAD;
      LEAD:  if (wrap) next_state = SHIFT;
      SHIFT: if (wrap && last_tog) next_state = TRAIL;
      TRAIL: if (wrap) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Edge decode and chip-select decode. The LEAD wrap is itself toggle 1, so
  // the toggle index of the edge happening now is tcnt+1 (odd = leading).
  always_comb begin
    wrap       = (cnt == CNT_MAX);
    tog        = wrap && ((state == LEAD) || (state == SHIFT));
    lead_edge  = tog && !tcnt[0];
    trail_edge = tog && tcnt[0];
    last_tog   = (tcnt == TCK_LAST);
    cs_dec     = '1;
    for (int unsigned i = 0; i < N_CS; i++) begin
      if (cs_sel == SEL_W'(i)) cs_dec[i] = 1'b0;
    end
  end

  // Registered datapath and outputs
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      tcnt    <= '0;
      cpha_q  <= 1'b0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      spi_clk <= 1'b0;
      cs_n    <= '1;
      mosi    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        cnt     <= '0;
        tcnt    <= '0;
        spi_clk <= mode[1];
        mosi    <= 1'b0;
        busy    <= 1'b0;
        if (start) begin
          busy   <= 1'b1;
          cs_n   <= cs_dec;
          cpha_q <= mode[0];
          tx_sh  <= tx_data;
          rx_sh  <= '0;
          mosi   <= mode[0] ? 1'b0 : tx_data[DATA_W-1];
        end
      end else begin
        cnt <= wrap ? '0 : cnt + 1'b1;
        if (tog) begin
          spi_clk <= ~spi_clk;
          tcnt    <= tcnt + 1'b1;
          if (cpha_q ? trail_edge : lead_edge)
            rx_sh <= {rx_sh[DATA_W-2:0], miso};
          if (!cpha_q && trail_edge && !last_tog) begin
            mosi  <= tx_sh[DATA_W-2];
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
          end
          if (cpha_q && lead_edge) begin
            mosi  <= tx_sh[DATA_W-1];
            tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
          end
        end
        if ((state == TRAIL) && wrap) begin
          cs_n    <= '1;
          rx_data <= rx_sh;
          done    <= 1'b1;
          busy    <= 1'b0;
          mosi    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: directed self-checking bench for spi_master_param.
// dut0: DATA_W=16, DIV=2, N_CS=2, SEL_W=2 with a behavioural SPI slave or
// loopback on miso. dut1: DATA_W=8, DIV=1 in loopback.
module tb_spi_master_param;

  logic        sclk = 1'b0;
  logic        rst;

  logic        start0;
  logic [15:0] tx0;
  logic [1:0]  sel0;
  logic [1:0]  mode0;
  logic [15:0] rx0;
  logic        busy0, done0, spi_clk0, mosi0, miso0;
  logic [1:0]  cs_n0;

  logic        start1;
  logic [7:0]  tx1;
  logic        sel1;
  logic [1:0]  mode1;
  logic [7:0]  rx1;
  logic        busy1, done1, spi_clk1, mosi1;
  logic [1:0]  cs_n1;

  logic        loop0;
  logic [15:0] slave_word;
  logic        tb_cpol, tb_cpha;
  logic        s_miso;
  logic [15:0] s_out, s_cap;
  logic        prev_act, prev_clk;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 sclk = ~sclk;

  assign miso0 = loop0 ? mosi0 : s_miso;

  spi_master_param #(.DATA_W(16), .DIV(2), .N_CS(2), .SEL_W(2)) dut0 (
    .sclk(sclk), .rst(rst), .start(start0), .tx_data(tx0), .cs_sel(sel0),
    .mode(mode0), .rx_data(rx0), .busy(busy0), .done(done0),
    .spi_clk(spi_clk0), .cs_n(cs_n0), .mosi(mosi0), .miso(miso0)
  );

  spi_master_param #(.DATA_W(8), .DIV(1), .N_CS(2), .SEL_W(1)) dut1 (
    .sclk(sclk), .rst(rst), .start(start1), .tx_data(tx1), .cs_sel(sel1),
    .mode(mode1), .rx_data(rx1), .busy(busy1), .done(done1),
    .spi_clk(spi_clk1), .cs_n(cs_n1), .mosi(mosi1), .miso(mosi1)
  );

  // Behavioural slave: captures mosi on sampling edges, shifts miso out on
  // the other edge; with CPHA=0 its MSB is presented at chip-select assertion.
  always @(negedge sclk) begin
    logic act, lead;
    act = (cs_n0 != 2'b11);
    if (act && !prev_act) begin
      s_out = slave_word;
      s_cap = '0;
      if (!tb_cpha) begin
        s_miso = s_out[15];
        s_out  = {s_out[14:0], 1'b0};
      end else begin
        s_miso = 1'b0;
      end
    end else if (act && (spi_clk0 != prev_clk)) begin
      lead = (spi_clk0 != tb_cpol);
      if (lead != tb_cpha) begin
        s_cap = {s_cap[14:0], mosi0};
      end else begin
        s_miso = s_out[15];
        s_out  = {s_out[14:0], 1'b0};
      end
    end
    prev_act = act;
    prev_clk = spi_clk0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] tx;
    logic [1:0]  sel;
    logic [1:0]  mode;
    logic        loop;
    logic [15:0] slave;
    logic [15:0] exp_rx;
    logic [1:0]  exp_cs;
  } vec_t;

  vec_t vecs[6];

  // One full transfer on dut0 with per-cycle monitoring; inputs are scrambled
  // right after acceptance to show they are latched.
  task automatic run0(input vec_t v);
    int   cyc, done_cyc, toggles;
    logic [1:0]  cs_first;
    logic [15:0] rx_before;
    logic bad, prev;
    @(negedge sclk);
    tx0 = v.tx; sel0 = v.sel; mode0 = v.mode; loop0 = v.loop;
    slave_word = v.slave; tb_cpol = v.mode[1]; tb_cpha = v.mode[0];
    @(negedge sclk);
    @(negedge sclk);
    chk("idle_spi_clk", 32'(spi_clk0), 32'(v.mode[1]));
    rx_before = rx0;
    start0 = 1'b1;
    @(posedge sclk); #1;
    start0 = 1'b0;
    tx0 = ~v.tx; mode0 = ~v.mode; sel0 = v.sel ^ 2'd1;
    cs_first = cs_n0;
    bad = !busy0;
    prev = spi_clk0;
    cyc = 0; done_cyc = -1; toggles = 0;
    while (done_cyc < 0 && cyc < 200) begin
      @(posedge sclk); #1;
      cyc++;
      if (spi_clk0 != prev) toggles++;
      prev = spi_clk0;
      if (done0) done_cyc = cyc;
      else if (cs_n0 != cs_first || !busy0 || rx0 != rx_before) bad = 1'b1;
    end
    chk("done_cycle", 32'(done_cyc), 32'd66);
    chk("toggles", 32'(toggles), 32'd32);
    chk("cs_n_during", 32'(cs_first), 32'(v.exp_cs));
    chk("stable_during", 32'(bad), 32'd0);
    chk("rx_data", 32'(rx0), 32'(v.exp_rx));
    chk("busy_at_done", 32'(busy0), 32'd0);
    chk("cs_n_at_done", 32'(cs_n0), 32'h3);
    chk("spi_clk_after", 32'(spi_clk0), 32'(v.mode[1]));
    if (!v.loop) chk("slave_capture", 32'(s_cap), 32'(v.tx));
    @(posedge sclk); #1;
    chk("done_one_cycle", 32'(done0), 32'd0);
    chk("rx_hold", 32'(rx0), 32'(v.exp_rx));
    mode0 = v.mode;
  endtask

  initial begin
    int cyc, d1, d2, highs, ndone, falls, dcyc;
    logic prev;

    vecs[0] = '{tx:16'hA5C3, sel:2'd0, mode:2'b00, loop:1'b1, slave:16'h0000, exp_rx:16'hA5C3, exp_cs:2'b10};
    vecs[1] = '{tx:16'hBEEF, sel:2'd0, mode:2'b11, loop:1'b0, slave:16'h1234, exp_rx:16'h1234, exp_cs:2'b10};
    vecs[2] = '{tx:16'h5A5A, sel:2'd1, mode:2'b00, loop:1'b1, slave:16'h0000, exp_rx:16'h5A5A, exp_cs:2'b01};
    vecs[3] = '{tx:16'h0F0F, sel:2'd3, mode:2'b00, loop:1'b1, slave:16'h0000, exp_rx:16'h0F0F, exp_cs:2'b11};
    vecs[4] = '{tx:16'h3C3C, sel:2'd1, mode:2'b01, loop:1'b0, slave:16'hC001, exp_rx:16'hC001, exp_cs:2'b01};
    vecs[5] = '{tx:16'h7E81, sel:2'd0, mode:2'b10, loop:1'b0, slave:16'h8421, exp_rx:16'h8421, exp_cs:2'b10};

    rst = 1'b1;
    start0 = 1'b0; tx0 = '0; sel0 = '0; mode0 = '0; loop0 = 1'b1;
    start1 = 1'b0; tx1 = '0; sel1 = '0; mode1 = '0;
    slave_word = '0; tb_cpol = 1'b0; tb_cpha = 1'b0;
    s_miso = 1'b0; s_out = '0; s_cap = '0; prev_act = 1'b0; prev_clk = 1'b0;
    repeat (3) @(negedge sclk);
    chk("rst_cs_n", 32'(cs_n0), 32'h3);
    chk("rst_spi_clk", 32'(spi_clk0), 32'd0);
    chk("rst_mosi", 32'(mosi0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_rx", 32'(rx0), 32'd0);
    chk("rst_cs_n_w8", 32'(cs_n1), 32'h3);
    rst = 1'b0;
    @(negedge sclk);

    for (int i = 0; i < 6; i++) run0(vecs[i]);

    // start held high: back-to-back transfers with a single high cs_n cycle
    @(negedge sclk);
    tx0 = 16'h1111; sel0 = 2'd0; mode0 = 2'b00; loop0 = 1'b1;
    tb_cpol = 1'b0; tb_cpha = 1'b0;
    @(negedge sclk);
    start0 = 1'b1;
    @(posedge sclk); #1;
    cyc = 0; d1 = -1; d2 = -1; highs = 0;
    while (d2 < 0 && cyc < 400) begin
      @(posedge sclk); #1;
      cyc++;
      if (done0) begin
        if (d1 < 0) d1 = cyc;
        else begin d2 = cyc; start0 = 1'b0; end
      end
      if (d1 >= 0 && d2 < 0 && cs_n0 == 2'b11) highs++;
    end
    start0 = 1'b0;
    chk("b2b_first_done", 32'(d1), 32'd66);
    chk("b2b_second_done", 32'(d2), 32'd133);
    chk("b2b_cs_high_cycles", 32'(highs), 32'd1);
    chk("b2b_rx", 32'(rx0), 32'h1111);
    repeat (3) @(negedge sclk);
    chk("b2b_no_third", 32'(busy0), 32'd0);

    // start pulse mid-transfer is ignored
    @(negedge sclk);
    tx0 = 16'h2468;
    start0 = 1'b1;
    @(posedge sclk); #1;
    start0 = 1'b0;
    cyc = 0; ndone = 0; dcyc = -1;
    while (cyc < 150) begin
      @(posedge sclk); #1;
      cyc++;
      if (cyc == 20) start0 = 1'b1;
      if (cyc == 21) start0 = 1'b0;
      if (done0) begin ndone++; if (dcyc < 0) dcyc = cyc; end
    end
    chk("midstart_done_count", 32'(ndone), 32'd1);
    chk("midstart_done_cycle", 32'(dcyc), 32'd66);
    chk("midstart_rx", 32'(rx0), 32'h2468);

    // asynchronous reset after toggle 9 (spi_clk high in mode 0)
    @(negedge sclk);
    tx0 = 16'hA5C3;
    start0 = 1'b1;
    @(posedge sclk); #1;
    start0 = 1'b0;
    repeat (19) begin @(posedge sclk); #1; end
    rst = 1'b1;
    #1;
    chk("arst_cs_n", 32'(cs_n0), 32'h3);
    chk("arst_spi_clk", 32'(spi_clk0), 32'd0);
    chk("arst_busy", 32'(busy0), 32'd0);
    chk("arst_done", 32'(done0), 32'd0);
    @(negedge sclk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge sclk); #1;
      if (done0) ndone++;
    end
    chk("arst_no_done", 32'(ndone), 32'd0);
    chk("arst_rx_cleared", 32'(rx0), 32'd0);
    run0(vecs[0]);

    // DATA_W=8, DIV=1, mode 1 loopback
    @(negedge sclk);
    tx1 = 8'h81; mode1 = 2'b01; sel1 = 1'b0;
    @(negedge sclk);
    @(negedge sclk);
    start1 = 1'b1;
    @(posedge sclk); #1;
    start1 = 1'b0;
    prev = spi_clk1;
    cyc = 0; dcyc = -1; falls = 0;
    while (dcyc < 0 && cyc < 60) begin
      @(posedge sclk); #1;
      cyc++;
      if (prev && !spi_clk1) falls++;
      prev = spi_clk1;
      if (done1) dcyc = cyc;
    end
    chk("w8_done_cycle", 32'(dcyc), 32'd17);
    chk("w8_falls", 32'(falls), 32'd8);
    chk("w8_rx", 32'(rx1), 32'h81);
    chk("w8_cs_n_after", 32'(cs_n1), 32'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
